// File: rtl/digit_glyph_plotter.sv
// digit_glyph_plotter
// Plots one packed 3x5 digit glyph into the VGA adapter's framebuffer write
// port. The glyph and its screen origin are snapshotted on start, and each
// glyph pixel is expanded to a SCALE x SCALE block. One write slot is issued
// per clock. Every output is registered.
// Build option: define DIGIT_GLYPH_SKIP_BLACK_EN to suppress vga_plot on
// black (3'b000) slots. Slot timing is unchanged, so the background shows
// through instead of being erased.
module digit_glyph_plotter #(
   parameter int SCALE = 1
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         start,
   input  logic [7:0]   x_base,
   input  logic [6:0]   y_base,
   input  logic [119:0] x_array,
   input  logic [119:0] y_array,
   input  logic [44:0]  colour_array,
   output logic [7:0]   vga_x,
   output logic [6:0]   vga_y,
   output logic [2:0]   vga_colour,
   output logic         vga_plot,
   output logic         busy,
   output logic         done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PLOT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int         NPIX    = 15;
   localparam logic [3:0] LAST_I  = 4'd14;
   localparam logic [1:0] LAST_S  = 2'(SCALE - 1);
   localparam logic [9:0] SCALE10 = 10'(SCALE);

   logic [1:0] state;
   logic [1:0] state_nxt;

   // glyph snapshot
   logic [7:0] xoff_q [NPIX];
   logic [7:0] yoff_q [NPIX];
   logic [2:0] col_q  [NPIX];
   logic [7:0] xb_q;
   logic [6:0] yb_q;

   // slot position: glyph entry, sub-row, sub-column
   logic [3:0] idx;
   logic [1:0] sy;
   logic [1:0] sx;

   logic       accept;
   logic       slot_last;
   logic [7:0] slot_x;
   logic [6:0] slot_y;
   logic [2:0] slot_col;
   logic       slot_wr;

   // Screen x of a slot: base + SCALE*offset + sub-column, 10-bit sum wrapped to 8 bits.
   function automatic logic [7:0] scr_x(input logic [7:0] base,
                                        input logic [7:0] off,
                                        input logic [1:0] sub);
      logic [9:0] sum;
      sum = {2'b00, base} + SCALE10 * {2'b00, off} + {8'd0, sub};
      return 8'(sum);
   endfunction

   // Screen y of a slot, wrapped to 7 bits. Offset bit 7 contributes
   // SCALE*128, and the 10-bit sum wraps at 1024. Both are multiples of 128,
   // so only yoff[6:0] affects the result.
   function automatic logic [6:0] scr_y(input logic [6:0] base,
                                        input logic [7:0] off,
                                        input logic [1:0] sub);
      logic [9:0] sum;
      sum = {3'b000, base} + SCALE10 * {2'b00, off} + {8'd0, sub};
      return 7'(sum);
   endfunction

   assign accept = (state == IDLE) && start;

   // Address, colour and end-of-glyph detection for the current slot.
   always_comb begin
      slot_x    = scr_x(xb_q, xoff_q[idx], sx);
      slot_y    = scr_y(yb_q, yoff_q[idx], sy);
      slot_col  = col_q[idx];
      slot_last = (idx == LAST_I) && (sy == LAST_S) && (sx == LAST_S);
   end

`ifdef DIGIT_GLYPH_SKIP_BLACK_EN
   assign slot_wr = (slot_col != 3'b000);
`else
   assign slot_wr = 1'b1;
`endif

   // Next-state selection for the IDLE -> PLOT -> DONE sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = PLOT;
         PLOT:    if (slot_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Snapshot the glyph and origin when a start is accepted.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int e = 0; e < NPIX; e++) begin
            xoff_q[e] <= 8'd0;
            yoff_q[e] <= 8'd0;
            col_q[e]  <= 3'd0;
         end
         xb_q <= 8'd0;
         yb_q <= 7'd0;
      end else if (accept) begin
         for (int e = 0; e < NPIX; e++) begin
            xoff_q[e] <= x_array[119 - 8*e -: 8];
            yoff_q[e] <= y_array[119 - 8*e -: 8];
            col_q[e]  <= colour_array[44 - 3*e -: 3];
         end
         xb_q <= x_base;
         yb_q <= y_base;
      end
   end

   // Walk slots in order: sub-column innermost, then sub-row, then glyph entry.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idx <= 4'd0;
         sy  <= 2'd0;
         sx  <= 2'd0;
      end else if (accept) begin
         idx <= 4'd0;
         sy  <= 2'd0;
         sx  <= 2'd0;
      end else if (state == PLOT) begin
         if (sx != LAST_S) begin
            sx <= sx + 2'd1;
         end else begin
            sx <= 2'd0;
            if (sy != LAST_S) begin
               sy <= sy + 2'd1;
            end else begin
               sy  <= 2'd0;
               idx <= (idx == LAST_I) ? 4'd0 : idx + 4'd1;
            end
         end
      end
   end

   // Registered framebuffer write port and status strobes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vga_x      <= 8'd0;
         vga_y      <= 7'd0;
         vga_colour <= 3'd0;
         vga_plot   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         vga_plot <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         case (state)
            PLOT: begin
               vga_x      <= slot_x;
               vga_y      <= slot_y;
               vga_colour <= slot_col;
               vga_plot   <= slot_wr;
               busy       <= 1'b1;
            end
            DONE:    done <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_digit_glyph_plotter.sv
// tb_digit_glyph_plotter
// Three plotters (SCALE 1, 2, 4) share the glyph/base inputs and have
// separate start lines. At each accepted start, a reference model expands the
// snapshot into the full list of expected write slots plus the done cycle.
// A compare process checks every cycle against that list. Directed scenarios
// pin known coordinates, and randomized runs follow them.
module tb_digit_glyph_plotter;

   localparam int ND = 3;
`ifdef DIGIT_GLYPH_SKIP_BLACK_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   localparam logic [14:0] DIG0 = 15'b111_101_101_101_111;
   localparam logic [14:0] DIG1 = 15'b001_001_001_001_001;
   localparam logic [14:0] DIG8 = 15'b111_101_111_101_111;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      logic       plot;
      logic       busy;
      logic       done;
   } exp_t;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [ND-1:0] start = '0;
   logic [7:0]    x_base = 8'd0;
   logic [6:0]    y_base = 7'd0;
   logic [119:0]  x_array = '0;
   logic [119:0]  y_array = '0;
   logic [44:0]   colour_array = '0;

   logic [7:0]    vx [ND];
   logic [6:0]    vy [ND];
   logic [2:0]    vc [ND];
   logic [ND-1:0] vp;
   logic [ND-1:0] vb;
   logic [ND-1:0] vd;

   exp_t q  [ND][$];
   exp_t ex [ND];

   int checks = 0;
   int errors = 0;
   int plot_cnt [ND] = '{0, 0, 0};
   int done_cnt [ND] = '{0, 0, 0};
   int busy_cnt [ND] = '{0, 0, 0};

   always #5 clk = ~clk;

   digit_glyph_plotter #(.SCALE(1)) dut0 (
      .clk(clk), .resetn(resetn), .start(start[0]), .x_base(x_base), .y_base(y_base),
      .x_array(x_array), .y_array(y_array), .colour_array(colour_array),
      .vga_x(vx[0]), .vga_y(vy[0]), .vga_colour(vc[0]), .vga_plot(vp[0]),
      .busy(vb[0]), .done(vd[0]));

   digit_glyph_plotter #(.SCALE(2)) dut1 (
      .clk(clk), .resetn(resetn), .start(start[1]), .x_base(x_base), .y_base(y_base),
      .x_array(x_array), .y_array(y_array), .colour_array(colour_array),
      .vga_x(vx[1]), .vga_y(vy[1]), .vga_colour(vc[1]), .vga_plot(vp[1]),
      .busy(vb[1]), .done(vd[1]));

   digit_glyph_plotter #(.SCALE(4)) dut2 (
      .clk(clk), .resetn(resetn), .start(start[2]), .x_base(x_base), .y_base(y_base),
      .x_array(x_array), .y_array(y_array), .colour_array(colour_array),
      .vga_x(vx[2]), .vga_y(vy[2]), .vga_colour(vc[2]), .vga_plot(vp[2]),
      .busy(vb[2]), .done(vd[2]));

   function automatic int scale_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
   endfunction

   function automatic exp_t mk(input logic p, input logic b, input logic dn);
      exp_t e;
      e = '0;
      e.plot = p;
      e.busy = b;
      e.done = dn;
      return e;
   endfunction

   // Expected write for slot j of a run, from plain arithmetic on the snapshot.
   function automatic exp_t slot_of(input int s, input int j,
                                    input logic [119:0] xa, input logic [119:0] ya,
                                    input logic [44:0] ca,
                                    input logic [7:0] xb, input logic [6:0] yb);
      exp_t e;
      int i, r, sx, sy, xo, yo;
      i  = j / (s * s);
      r  = j % (s * s);
      sy = r / s;
      sx = r % s;
      xo = int'(xa[119 - 8*i -: 8]);
      yo = int'(ya[119 - 8*i -: 8]) % 128;
      e      = '0;
      e.x    = 8'((int'(xb) + s * xo + sx) % 256);
      e.y    = 7'((int'(yb) + s * yo + sy) % 128);
      e.c    = ca[44 - 3*i -: 3];
      e.plot = SKIP ? (e.c != 3'b000) : 1'b1;
      e.busy = 1'b1;
      return e;
   endfunction

   task automatic check(input string nm, input int act, input int want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
      end
   endtask

   task automatic set_digit(input logic [14:0] pat, input logic [7:0] xb, input logic [6:0] yb);
      for (int i = 0; i < 15; i++) begin
         x_array[119 - 8*i -: 8]    = 8'(i % 3);
         y_array[119 - 8*i -: 8]    = 8'(i / 3);
         colour_array[44 - 3*i -: 3] = pat[14 - i] ? 3'b111 : 3'b000;
      end
      x_base = xb;
      y_base = yb;
   endtask

   task automatic randomize_inputs();
      logic [127:0] rx, ry;
      logic [63:0]  rc;
      rx = {$urandom(), $urandom(), $urandom(), $urandom()};
      ry = {$urandom(), $urandom(), $urandom(), $urandom()};
      rc = {$urandom(), $urandom()};
      x_array      = rx[119:0];
      y_array      = ry[119:0];
      colour_array = rc[44:0];
      x_base       = 8'($urandom());
      y_base       = 7'($urandom());
   endtask

   // Single-cycle start pulse, returning at the falling edge after acceptance.
   task automatic do_start(input int d);
      @(negedge clk);
      start[d] = 1'b1;
      @(negedge clk);
      start = '0;
   endtask

   // Reference model: an accepted start queues every slot followed by the done cycle.
   always @(posedge clk) begin
      for (int d = 0; d < ND; d++) begin
         if (!resetn) begin
            q[d].delete();
            ex[d] <= mk(1'b0, 1'b0, 1'b0);
         end else if (q[d].size() > 0) begin
            ex[d] <= q[d].pop_front();
         end else begin
            ex[d] <= mk(1'b0, 1'b0, 1'b0);
            if (start[d]) begin
               for (int j = 0; j < 15 * scale_of(d) * scale_of(d); j++)
                  q[d].push_back(slot_of(scale_of(d), j, x_array, y_array, colour_array,
                                         x_base, y_base));
               q[d].push_back(mk(1'b0, 1'b0, 1'b1));
            end
         end
      end
   end

   // Compare every DUT output with the model on each falling edge.
   always @(negedge clk) begin
      for (int d = 0; d < ND; d++) begin
         if (!resetn) begin
            check($sformatf("dut%0d outputs in reset", d),
                  int'({vx[d], vy[d], vc[d], vp[d], vb[d], vd[d]}), 0);
         end else begin
            check($sformatf("dut%0d vga_plot", d), int'(vp[d]), int'(ex[d].plot));
            check($sformatf("dut%0d busy", d), int'(vb[d]), int'(ex[d].busy));
            check($sformatf("dut%0d done", d), int'(vd[d]), int'(ex[d].done));
            if (ex[d].plot) begin
               check($sformatf("dut%0d vga_x", d), int'(vx[d]), int'(ex[d].x));
               check($sformatf("dut%0d vga_y", d), int'(vy[d]), int'(ex[d].y));
               check($sformatf("dut%0d vga_colour", d), int'(vc[d]), int'(ex[d].c));
            end
         end
         plot_cnt[d] += int'(vp[d]);
         done_cnt[d] += int'(vd[d]);
         busy_cnt[d] += int'(vb[d]);
      end
   end

   initial begin
      int p0, d0, b0, n, d, hold;

      repeat (2) @(negedge clk);
      for (int k = 0; k < ND; k++)
         check($sformatf("reset state dut%0d", k),
               int'({vx[k], vy[k], vc[k], vp[k], vb[k], vd[k]}), 0);
      resetn = 1'b1;

      // Digit 1, SCALE 1, origin (10,20)
      set_digit(DIG1, 8'd10, 7'd20);
      #1 p0 = plot_cnt[0]; d0 = done_cnt[0];
      do_start(0);
      @(negedge clk);
      check("d1 slot0 x", int'(vx[0]), 10);
      check("d1 slot0 y", int'(vy[0]), 20);
      check("d1 slot0 colour", int'(vc[0]), 0);
      check("d1 slot0 plot", int'(vp[0]), SKIP ? 0 : 1);
      repeat (2) @(negedge clk);
      check("d1 slot2 x", int'(vx[0]), 12);
      check("d1 slot2 y", int'(vy[0]), 20);
      check("d1 slot2 colour", int'(vc[0]), 7);
      check("d1 slot2 plot", int'(vp[0]), 1);
      repeat (12) @(negedge clk);
      check("d1 slot14 y", int'(vy[0]), 24);
      check("d1 slot14 busy", int'(vb[0]), 1);
      @(negedge clk);
      check("d1 done pulse", int'(vd[0]), 1);
      check("d1 busy after last", int'(vb[0]), 0);
      @(negedge clk);
      check("d1 done single", int'(vd[0]), 0);
      #1;
      check("d1 plot count", plot_cnt[0] - p0, SKIP ? 5 : 15);
      check("d1 done count", done_cnt[0] - d0, 1);

      // Digit 8, SCALE 2, origin (0,0)
      set_digit(DIG8, 8'd0, 7'd0);
      #1 b0 = busy_cnt[1]; d0 = done_cnt[1];
      do_start(1);
      @(negedge clk);
      repeat (16) @(negedge clk);
      check("d8 px4 a x", int'(vx[1]), 2);
      check("d8 px4 a y", int'(vy[1]), 2);
      check("d8 px4 colour", int'(vc[1]), 0);
      @(negedge clk);
      check("d8 px4 b x", int'(vx[1]), 3);
      check("d8 px4 b y", int'(vy[1]), 2);
      @(negedge clk);
      check("d8 px4 c x", int'(vx[1]), 2);
      check("d8 px4 c y", int'(vy[1]), 3);
      @(negedge clk);
      check("d8 px4 d x", int'(vx[1]), 3);
      check("d8 px4 d y", int'(vy[1]), 3);
      repeat (40) @(negedge clk);
      check("d8 last x", int'(vx[1]), 5);
      check("d8 last y", int'(vy[1]), 9);
      check("d8 last plot", int'(vp[1]), 1);
      repeat (3) @(negedge clk);
      #1;
      check("d8 busy cycles", busy_cnt[1] - b0, 60);
      check("d8 done count", done_cnt[1] - d0, 1);

      // Wrap at the screen corner, digit 0, SCALE 1
      set_digit(DIG0, 8'd255, 7'd127);
      do_start(0);
      repeat (2) @(negedge clk);
      check("wrap slot1 x", int'(vx[0]), 0);
      check("wrap slot1 y", int'(vy[0]), 127);
      repeat (2) @(negedge clk);
      check("wrap slot3 x", int'(vx[0]), 255);
      check("wrap slot3 y", int'(vy[0]), 0);
      repeat (16) @(negedge clk);

      // A start during a run must be ignored and not queued
      set_digit(DIG8, 8'd30, 7'd40);
      #1 p0 = plot_cnt[1]; d0 = done_cnt[1];
      do_start(1);
      repeat (4) @(negedge clk);
      set_digit(DIG1, 8'd100, 7'd60);
      start[1] = 1'b1;
      @(negedge clk);
      start = '0;
      repeat (70) @(negedge clk);
      #1;
      check("interference done count", done_cnt[1] - d0, 1);
      check("interference plot count", plot_cnt[1] - p0, SKIP ? 52 : 60);

      // Reset in the middle of a run
      set_digit(DIG8, 8'd50, 7'd50);
      do_start(0);
      repeat (6) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      for (int k = 0; k < ND; k++)
         check($sformatf("async reset dut%0d", k),
               int'({vx[k], vy[k], vc[k], vp[k], vb[k], vd[k]}), 0);
      repeat (2) @(negedge clk);
      #2 resetn = 1'b1;
      #1 p0 = plot_cnt[0]; d0 = done_cnt[0];
      repeat (20) @(negedge clk);
      #1;
      check("post-reset plot count", plot_cnt[0] - p0, 0);
      check("post-reset done count", done_cnt[0] - d0, 0);

      // Randomized glyphs, origins, start lengths and back-to-back runs
      for (int r = 0; r < 24; r++) begin
         d = r % ND;
         n = 15 * scale_of(d) * scale_of(d);
         randomize_inputs();
         hold = (r % 4 == 3) ? n + 3 : int'($urandom_range(1, 3));
         @(negedge clk);
         start[d] = 1'b1;
         repeat (hold) @(negedge clk);
         start = '0;
         randomize_inputs();
         repeat (2 * (n + 2) + int'($urandom_range(0, 3))) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
